// File: rtl/rc_filter_scheduler.sv
// -----------------------------------------------------------------------------
// rc_filter_scheduler
//
// Time-multiplexed sequencer for the discrete-time RC sound-circuit models.
// One shared signed W x W multiplier/accumulator evaluates NCH first-order
// filters once per audio sample tick:
//
//     s[n+1] = c0*s[n] + c1*x1 + ... + c(NTERM-1)*x(NTERM-1)
//
// Coefficients are Q1.(W-1) and loadable at runtime. Each channel state is
// kept with GUARD extra fraction bits. Only the upper W bits are fed back and
// published.
//
// Frame sequencing: IDLE -> (MAC x NTERM -> WB) x NCH -> DONE -> IDLE.
// A tick in cycle T gives out_valid in cycle T+1+NCH*(NTERM+1).
//
// Build option:
//   RC_SCHED_SAT_EN  defined     : write-back clamps state to its signed range
//                    not defined : write-back keeps the low W+GUARD bits (wraps)
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   sample_tick  in   one-cycle strobe that starts a frame
//   in_bus       in   channel ch, term t at [((ch*(NTERM-1))+t-1)*W +: W]
//   cfg_we       in   coefficient write strobe
//   cfg_addr     in   coefficient index = ch*NTERM + t
//   cfg_data     in   coefficient value, Q1.(W-1)
//   out_bus      out  channel ch state at [ch*W +: W]
//   out_valid    out  one-cycle pulse, out_bus updated this cycle
//   busy         out  high while a frame is in progress
//   overrun      out  sticky, set when sample_tick arrives while busy
// -----------------------------------------------------------------------------
module rc_filter_scheduler #(
    parameter int W     = 16,
    parameter int NCH   = 4,
    parameter int NTERM = 4,
    parameter int GUARD = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_tick,
    input  logic [NCH*(NTERM-1)*W-1:0]    in_bus,
    input  logic                          cfg_we,
    input  logic [$clog2(NCH*NTERM)-1:0]  cfg_addr,
    input  logic [W-1:0]                  cfg_data,
    output logic [NCH*W-1:0]              out_bus,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int AW    = $clog2(NCH*NTERM);
    localparam int NC    = NCH*NTERM;
    localparam int SW    = W + GUARD;                 // state register width
    localparam int ACCW  = 2*W + $clog2(NTERM);       // accumulator, never overflows
    localparam int SHIFT = W - 1 - GUARD;             // Q2.(2W-2) product -> state scale
    localparam int HW    = ACCW - SHIFT;              // width of the rescaled accumulator
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW    = (NTERM > 1) ? $clog2(NTERM) : 1;

`ifdef RC_SCHED_SAT_EN
    localparam logic signed [HW-1:0] SAT_MAX = {{(HW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [HW-1:0] SAT_MIN = {{(HW-SW+1){1'b1}}, {(SW-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } fsm_t;

    fsm_t                    fsm_q, fsm_d;
    logic [CHW-1:0]          ch_q, ch_d;
    logic [TW-1:0]           t_q, t_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic signed [SW-1:0]    state_q [NCH];
    logic signed [SW-1:0]    state_d [NCH];
    // Snapshot of the external inputs; term index 0 is never loaded (feedback term).
    logic signed [W-1:0]     x_q [NCH][NTERM];
    logic signed [W-1:0]     x_d [NCH][NTERM];
    logic signed [W-1:0]     coef_q [NC];
    logic signed [W-1:0]     coef_d [NC];
    logic [NCH*W-1:0]        out_bus_q, out_bus_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;

    logic [AW-1:0]           coef_idx_s;
    logic signed [W-1:0]     operand_s;
    logic signed [W-1:0]     coef_s;
    logic signed [2*W-1:0]   prod_s;
    logic signed [HW-1:0]    acc_hi_s;
    logic signed [SW-1:0]    wb_val_s;
    logic                    unused_s;

    // Coefficient table update; a write lands at the next edge, so a MAC reading
    // the same entry in the write cycle still sees the previous value.
    always_comb begin
        coef_d = coef_q;
        if (cfg_we && (int'(cfg_addr) < NC)) begin
            coef_d[cfg_addr] = cfg_data;
        end else begin
            coef_d = coef_q;
        end
    end

    // Operand/coefficient selection and the shared multiplier.
    always_comb begin
        coef_idx_s = AW'(ch_q) * AW'(NTERM) + AW'(t_q);
        coef_s     = coef_q[coef_idx_s];
        if (t_q == {TW{1'b0}}) begin
            operand_s = state_q[ch_q][SW-1:GUARD];
        end else begin
            operand_s = x_q[ch_q][t_q];
        end
        // Sign-extended operands make the unsigned 2W-bit product equal to the signed one.
        prod_s = {{W{operand_s[W-1]}}, operand_s} * {{W{coef_s[W-1]}}, coef_s};
    end

    // Rescale the accumulator to state precision and fit it into SW bits.
    always_comb begin
        acc_hi_s = acc_q[ACCW-1:SHIFT];
`ifdef RC_SCHED_SAT_EN
        if (acc_hi_s > SAT_MAX) begin
            wb_val_s = SAT_MAX[SW-1:0];
        end else if (acc_hi_s < SAT_MIN) begin
            wb_val_s = SAT_MIN[SW-1:0];
        end else begin
            wb_val_s = acc_hi_s[SW-1:0];
        end
`else
        wb_val_s = acc_hi_s[SW-1:0];
`endif
    end

    // Bits that are dropped by design (rounding fraction and guard bits).
    always_comb begin
        unused_s = ^acc_q[SHIFT-1:0];
        for (int c = 0; c < NCH; c++) begin
            unused_s = unused_s ^ (^state_q[c][GUARD-1:0]);
        end
`ifndef RC_SCHED_SAT_EN
        unused_s = unused_s ^ (^acc_hi_s[HW-1:SW]);
`endif
    end

    // Next-state and datapath control for the frame sequencer.
    always_comb begin
        fsm_d     = fsm_q;
        ch_d      = ch_q;
        t_d       = t_q;
        acc_d     = acc_q;
        state_d   = state_q;
        x_d       = x_q;
        out_bus_d = out_bus_q;

        // Any tick outside IDLE (including the DONE cycle) is dropped and flagged.
        if (sample_tick && (fsm_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (fsm_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    for (int c = 0; c < NCH; c++) begin
                        x_d[c][0] = {W{1'b0}};
                        for (int t = 1; t < NTERM; t++) begin
                            x_d[c][t] = in_bus[((c*(NTERM-1))+t-1)*W +: W];
                        end
                    end
                    ch_d  = {CHW{1'b0}};
                    t_d   = {TW{1'b0}};
                    acc_d = {ACCW{1'b0}};
                    fsm_d = ST_MAC;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + {{(ACCW-2*W){prod_s[2*W-1]}}, prod_s};
                if (t_q == TW'(NTERM-1)) begin
                    t_d   = {TW{1'b0}};
                    fsm_d = ST_WB;
                end else begin
                    t_d   = t_q + {{(TW-1){1'b0}}, 1'b1};
                    fsm_d = ST_MAC;
                end
            end
            ST_WB: begin
                state_d[ch_q] = wb_val_s;
                acc_d         = {ACCW{1'b0}};
                if (ch_q == CHW'(NCH-1)) begin
                    ch_d  = {CHW{1'b0}};
                    fsm_d = ST_DONE;
                    // Publish every channel at once, including the one written now.
                    for (int c = 0; c < NCH; c++) begin
                        out_bus_d[c*W +: W] = state_d[c][SW-1:GUARD];
                    end
                end else begin
                    ch_d  = ch_q + {{(CHW-1){1'b0}}, 1'b1};
                    fsm_d = ST_MAC;
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase

        out_valid_d = (fsm_d == ST_DONE);
        busy_d      = (fsm_d != ST_IDLE);
    end

    // State register for sequencer, datapath, tables and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            ch_q        <= {CHW{1'b0}};
            t_q         <= {TW{1'b0}};
            acc_q       <= {ACCW{1'b0}};
            out_bus_q   <= {(NCH*W){1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= {SW{1'b0}};
                for (int t = 0; t < NTERM; t++) begin
                    x_q[c][t] <= {W{1'b0}};
                end
            end
            for (int i = 0; i < NC; i++) begin
                coef_q[i] <= {W{1'b0}};
            end
        end else begin
            fsm_q       <= fsm_d;
            ch_q        <= ch_d;
            t_q         <= t_d;
            acc_q       <= acc_d;
            out_bus_q   <= out_bus_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            state_q     <= state_d;
            x_q         <= x_d;
            coef_q      <= coef_d;
        end
    end

    assign out_bus   = out_bus_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rc_filter_scheduler.sv
// Scoreboard bench for rc_filter_scheduler: stimulus pushes hand-computed
// frame results (and the cycle they are due), a monitor pops on out_valid.
module tb_rc_filter_scheduler;

    localparam int W     = 16;
    localparam int NCH   = 4;
    localparam int NTERM = 4;
    localparam int GUARD = 4;
    localparam int LAT   = 1 + NCH*(NTERM+1);

`ifdef RC_SCHED_SAT_EN
    localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
    localparam logic [15:0] SAT_EXP = 16'h7FFA;
`endif

    logic                       clk;
    logic                       rst;
    logic                       sample_tick;
    logic [NCH*(NTERM-1)*W-1:0] in_bus;
    logic                       cfg_we;
    logic [3:0]                 cfg_addr;
    logic [W-1:0]               cfg_data;
    logic [NCH*W-1:0]           out_bus;
    logic                       out_valid;
    logic                       busy;
    logic                       overrun;

    typedef struct {
        logic [63:0] bus;
        int          when;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;
    int   cyc;

    rc_filter_scheduler #(.W(W), .NCH(NCH), .NTERM(NTERM), .GUARD(GUARD)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_tick(sample_tick),
        .in_bus     (in_bus),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .out_bus    (out_bus),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input int ch, input int t, input logic [15:0] val);
        in_bus[((ch*(NTERM-1))+t-1)*W +: W] = val;
    endtask

    task automatic cfg(input logic [3:0] addr, input logic [15:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic tick_exp(input logic [63:0] bus, input string name);
        exp_t e;
        e.bus  = bus;
        e.when = cyc + LAT;
        e.name = name;
        sample_tick = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk({name, "_drain"}, 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t0;
        int ov_seen;
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        rst         = 1'b1;
        sample_tick = 1'b0;
        in_bus      = '0;
        cfg_we      = 1'b0;
        cfg_addr    = 4'd0;
        cfg_data    = 16'd0;

        // Monitor: pops one expectation per out_valid pulse.
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_out_valid actual=1 required=0 cycle=%0d", cyc);
                        end else begin
                            e = sb.pop_front();
                            chk({e.name, "_bus"}, out_bus, e.bus);
                            chk({e.name, "_cycle"}, 64'(cyc), 64'(e.when));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_out_bus", out_bus, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Gain: 0.5 * 0x2000 on ch0.
        cfg(4'd1, 16'h4000);
        set_in(0, 1, 16'h2000);
        t0 = cyc;
        tick_exp(64'h0000_0000_0000_1000, "gain");
        chk("busy_first", 64'(busy), 64'd1);
        while (cyc < t0 + LAT) @(negedge clk);
        chk("busy_done_cycle", 64'(busy), 64'd1);
        @(negedge clk);
        chk("busy_after", 64'(busy), 64'd0);
        wait_drain("gain");

        // Feedback: ch2 s' = 0.5*s + 0.5*0x4000.
        cfg(4'd8, 16'h4000);
        cfg(4'd9, 16'h4000);
        set_in(2, 1, 16'h4000);
        tick_exp(64'h0000_2000_0000_1000, "fb1");
        wait_drain("fb1");
        tick_exp(64'h0000_3000_0000_1000, "fb2");
        wait_drain("fb2");
        tick_exp(64'h0000_3800_0000_1000, "fb3");
        wait_drain("fb3");

        // Saturation / wrap on ch1.
        cfg(4'd5, 16'h7FFF);
        cfg(4'd6, 16'h7FFF);
        cfg(4'd7, 16'h7FFF);
        set_in(1, 1, 16'h7FFF);
        set_in(1, 2, 16'h7FFF);
        set_in(1, 3, 16'h7FFF);
        tick_exp({16'h0000, 16'h3C00, SAT_EXP, 16'h1000}, "sat");
        wait_drain("sat");

        // Overrun: second tick five cycles after the first is dropped.
        chk("overrun_clear", 64'(overrun), 64'd0);
        t0 = cyc;
        tick_exp({16'h0000, 16'h3E00, SAT_EXP, 16'h1000}, "ovr");
        while (cyc < t0 + 5) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("overrun_set", 64'(overrun), 64'd1);
        wait_drain("ovr");

        // Snapshot and cfg race on ch3.
        cfg(4'd13, 16'h4000);
        cfg(4'd14, 16'h2000);
        set_in(3, 1, 16'h2000);
        set_in(3, 2, 16'h4000);
        t0 = cyc;
        tick_exp({16'h2000, 16'h3F00, SAT_EXP, 16'h1000}, "race");
        while (cyc < t0 + 3) @(negedge clk);
        set_in(3, 1, 16'h7000);
        set_in(0, 1, 16'h6000);
        // ch3 term 1 is multiplied in this very cycle.
        while (cyc < t0 + 17) @(negedge clk);
        cfg(4'd13, 16'h0000);
        chk("overrun_sticky", 64'(overrun), 64'd1);
        wait_drain("race");
        tick_exp({16'h1000, 16'h3F80, SAT_EXP, 16'h3000}, "race_next");
        wait_drain("race_next");

        // Reset in the middle of a frame.
        t0 = cyc;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        while (cyc < t0 + 8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_out_bus", out_bus, 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_overrun", 64'(overrun), 64'd0);
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        chk("midrst_no_valid", 64'(ov_seen), 64'd0);
        chk("midrst_out_hold", out_bus, 64'd0);
        // Coefficients are cleared, so a frame with live inputs yields zero.
        tick_exp(64'h0000_0000_0000_0000, "post_rst");
        wait_drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
